// File: rtl/receive_if.sv
// Processor/baud-side signal bundle of the SPART receiver: tick, register decode, serial in, status out.
interface receive_if;
    logic       brg_sample;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rda;
    logic       framing_err;
    logic       overrun;

    modport master (
        output brg_sample, iocs, iorw, ioaddr, rxd,
        input  rx_data, rda, framing_err, overrun
    );

    modport slave (
        input  brg_sample, iocs, iorw, ioaddr, rxd,
        output rx_data, rda, framing_err, overrun
    );
endinterface

// File: rtl/receive.sv
// SPART 8N1 receiver; byte lands 2 clk + <=1 tick + (OVERSAMPLE/2 + 9*OVERSAMPLE) ticks after the start edge.
// No backpressure: a byte that is not read in time is overwritten and flagged as overrun.
module receive #(
    parameter int OVERSAMPLE = 16
) (
    input logic       clk,
    input logic       rst,
    receive_if.slave  bus
);
    localparam int            TW      = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_M1 = TW'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t        r_state, w_state_nxt;
    logic          r_sync1, r_sync2;
    logic [TW-1:0] r_tcnt, w_tcnt_nxt;
    logic [2:0]    r_bcnt, w_bcnt_nxt;
    logic [7:0]    r_sr, w_sr_nxt;
    logic [7:0]    r_rx_data;
    logic          r_rda, r_framing_err, r_overrun;
    logic          w_rxd_s, w_load, w_buf_rd, w_stat_rd;

    assign w_rxd_s   = r_sync2;
    assign w_buf_rd  = bus.iocs & bus.iorw & (bus.ioaddr == 2'd0);
    assign w_stat_rd = bus.iocs & bus.iorw & (bus.ioaddr == 2'd1);

    always_comb begin
        w_state_nxt = r_state;
        w_tcnt_nxt  = r_tcnt;
        w_bcnt_nxt  = r_bcnt;
        w_sr_nxt    = r_sr;
        w_load      = 1'b0;
        if (bus.brg_sample) begin
            case (r_state)
                S_IDLE: begin
                    if (!w_rxd_s) begin
                        w_state_nxt = S_START;
                        w_tcnt_nxt  = '0;
                    end
                end
                S_START: begin
                    // A start bit that is gone by its midpoint was noise.
                    if (r_tcnt == HALF_M1) begin
                        w_tcnt_nxt  = '0;
                        w_bcnt_nxt  = '0;
                        w_state_nxt = w_rxd_s ? S_IDLE : S_DATA;
                    end else begin
                        w_tcnt_nxt = r_tcnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_tcnt == FULL_M1) begin
                        w_sr_nxt   = {w_rxd_s, r_sr[7:1]};
                        w_tcnt_nxt = '0;
                        if (r_bcnt == 3'd7) begin
                            w_state_nxt = S_STOP;
                        end else begin
                            w_bcnt_nxt = r_bcnt + 3'd1;
                        end
                    end else begin
                        w_tcnt_nxt = r_tcnt + 1'b1;
                    end
                end
                S_STOP: begin
                    // Finish at mid stop bit so a following start edge is never missed.
                    if (r_tcnt == FULL_M1) begin
                        w_load      = 1'b1;
                        w_tcnt_nxt  = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_tcnt_nxt = r_tcnt + 1'b1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_tcnt  <= '0;
            r_bcnt  <= '0;
            r_sr    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sync1 <= bus.rxd;
            r_sync2 <= r_sync1;
            r_tcnt  <= w_tcnt_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_sr    <= w_sr_nxt;
        end
    end

    // A load outranks a same-cycle read: sets win over clears.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rx_data     <= 8'h00;
            r_rda         <= 1'b0;
            r_framing_err <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            if (w_load) begin
                r_rx_data <= r_sr;
            end
            r_rda         <= w_load | (r_rda & ~w_buf_rd);
            r_framing_err <= (w_load & ~w_rxd_s) | (r_framing_err & ~w_stat_rd);
            r_overrun     <= (w_load & r_rda & ~w_buf_rd) | (r_overrun & ~w_stat_rd);
        end
    end

    assign bus.rx_data     = r_rx_data;
    assign bus.rda         = r_rda;
    assign bus.framing_err = r_framing_err;
    assign bus.overrun     = r_overrun;
endmodule

// File: tb/tb_receive.sv
// Bench for the SPART receiver at OVERSAMPLE 16 (tick every 4 clk), 8 and 32 (tick held high).
module tb_receive;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] div = 2'd0;
    logic       iocs, iorw;
    logic [1:0] ioaddr;
    logic       rxd_d [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) div <= div + 2'd1;

    receive_if if16 ();
    receive_if if8 ();
    receive_if if32 ();

    assign if16.brg_sample = (div == 2'd3);
    assign if8.brg_sample  = 1'b1;
    assign if32.brg_sample = 1'b1;
    assign if16.iocs = iocs;  assign if16.iorw = iorw;  assign if16.ioaddr = ioaddr;
    assign if8.iocs  = iocs;  assign if8.iorw  = iorw;  assign if8.ioaddr  = ioaddr;
    assign if32.iocs = iocs;  assign if32.iorw = iorw;  assign if32.ioaddr = ioaddr;
    assign if16.rxd = rxd_d[0];
    assign if8.rxd  = rxd_d[1];
    assign if32.rxd = rxd_d[2];

    receive #(.OVERSAMPLE(16)) u_dut16 (.clk(clk), .rst(rst), .bus(if16));
    receive #(.OVERSAMPLE(8))  u_dut8  (.clk(clk), .rst(rst), .bus(if8));
    receive #(.OVERSAMPLE(32)) u_dut32 (.clk(clk), .rst(rst), .bus(if32));

    typedef struct {
        logic       rdbuf;
        logic       rdst;
        logic [7:0] data;
        logic       stop;
        logic [7:0] exp_data;
        logic       exp_rda;
        logic       exp_fe;
        logic       exp_ov;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic check_out(input int k, input string tag, input logic [7:0] d,
                             input logic r, input logic f, input logic o);
        logic [7:0] ad;
        logic       ar, af, ao;
        case (k)
            0:       begin ad = if16.rx_data; ar = if16.rda; af = if16.framing_err; ao = if16.overrun; end
            1:       begin ad = if8.rx_data;  ar = if8.rda;  af = if8.framing_err;  ao = if8.overrun;  end
            default: begin ad = if32.rx_data; ar = if32.rda; af = if32.framing_err; ao = if32.overrun; end
        endcase
        check({tag, " rx_data"}, ad, d);
        check({tag, " rda"}, {7'd0, ar}, {7'd0, r});
        check({tag, " framing_err"}, {7'd0, af}, {7'd0, f});
        check({tag, " overrun"}, {7'd0, ao}, {7'd0, o});
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_op(input logic rw, input logic [1:0] addr);
        iocs = 1'b1; iorw = rw; ioaddr = addr;
        @(negedge clk);
        iocs = 1'b0; iorw = 1'b0; ioaddr = 2'd0;
    endtask

    // One 8N1 frame on DUT k. rd_at / rst_at: clock index within the frame for a
    // one-cycle buffer read / reset pulse (-1 = none).
    task automatic send_frame(input int k, input logic [7:0] b, input logic stop,
                              input int rd_at, input int rst_at);
        int   bitclk;
        int   bi;
        logic v;
        bitclk = (k == 0) ? 64 : (k == 1) ? 8 : 32;
        // For the divided tick, place the start edge so detection lands 2 clk later.
        if (k == 0) while (div != 2'd1) @(negedge clk);
        for (int i = 0; i < 10 * bitclk; i++) begin
            bi = i / bitclk;
            if (bi == 0)      v = 1'b0;
            else if (bi == 9) v = stop;
            else              v = b[bi - 1];
            rxd_d[k] = v;
            if (rd_at >= 0) begin
                iocs = (i == rd_at); iorw = 1'b1; ioaddr = 2'd0;
            end
            if (rst_at >= 0) rst = (i != rst_at);
            @(negedge clk);
        end
        rxd_d[k] = 1'b1;
        iocs = 1'b0;
    endtask

    logic [7:0] m_data;
    logic       m_rda, m_fe, m_ov;
    logic [7:0] rb;
    logic       rs;
    int         op;

    initial begin
        tbl[0] = '{1'b0, 1'b1, 8'h11, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1};
        tbl[1] = '{1'b0, 1'b1, 8'h22, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 8'h5A, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 8'hC3, 1'b0, 8'hC3, 1'b1, 1'b1, 1'b1};
        tbl[4] = '{1'b1, 1'b1, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};

        rst = 1'b0; iocs = 1'b0; iorw = 1'b0; ioaddr = 2'd0;
        for (int k = 0; k < 3; k++) rxd_d[k] = 1'b1;
        idle(3);
        check_out(0, "reset16", 8'h00, 1'b0, 1'b0, 1'b0);
        check_out(1, "reset8", 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        idle(10);

        send_frame(0, 8'hA5, 1'b1, -1, -1);
        check_out(0, "single A5", 8'hA5, 1'b1, 1'b0, 1'b0);
        bus_op(1'b1, 2'd0);
        check("buffer read clears rda", {7'd0, if16.rda}, 8'd0);
        idle(64);

        rxd_d[0] = 1'b0;
        idle(20);
        rxd_d[0] = 1'b1;
        idle(160);
        check("glitch rda", {7'd0, if16.rda}, 8'd0);
        check("glitch framing_err", {7'd0, if16.framing_err}, 8'd0);
        send_frame(0, 8'h3C, 1'b1, -1, -1);
        check_out(0, "after glitch 3C", 8'h3C, 1'b1, 1'b0, 1'b0);
        idle(64);

        for (int t = 0; t < 5; t++) begin
            if (tbl[t].rdbuf) bus_op(1'b1, 2'd0);
            if (tbl[t].rdst)  bus_op(1'b1, 2'd1);
            send_frame(0, tbl[t].data, tbl[t].stop, -1, -1);
            check_out(0, $sformatf("table[%0d]", t), tbl[t].exp_data, tbl[t].exp_rda,
                      tbl[t].exp_fe, tbl[t].exp_ov);
            idle(64);
        end

        bus_op(1'b1, 2'd0);
        send_frame(0, 8'h0F, 1'b0, -1, -1);
        check_out(0, "framing 0F", 8'h0F, 1'b1, 1'b1, 1'b0);
        idle(64);
        bus_op(1'b1, 2'd1);
        check("status read clears framing_err", {7'd0, if16.framing_err}, 8'd0);
        check("status read keeps rda", {7'd0, if16.rda}, 8'd1);

        bus_op(1'b1, 2'd0);
        send_frame(0, 8'h11, 1'b1, -1, -1);
        send_frame(0, 8'h22, 1'b1, -1, -1);
        check_out(0, "back-to-back", 8'h22, 1'b1, 1'b0, 1'b1);
        idle(64);
        bus_op(1'b1, 2'd1);
        bus_op(1'b1, 2'd0);
        send_frame(0, 8'h11, 1'b1, -1, -1);
        // Second load happens 2 + 4*(8 + 9*16) = 610 clk after its start edge.
        send_frame(0, 8'h22, 1'b1, 610, -1);
        check_out(0, "read on load", 8'h22, 1'b1, 1'b0, 1'b0);
        idle(64);

        send_frame(0, 8'hFF, 1'b1, -1, 5 * 64);
        check_out(0, "reset mid-frame", 8'h00, 1'b0, 1'b0, 1'b0);
        idle(64);
        send_frame(0, 8'h81, 1'b1, -1, -1);
        check_out(0, "after reset 81", 8'h81, 1'b1, 1'b0, 1'b0);
        idle(64);

        for (int k = 1; k < 3; k++) begin
            bus_op(1'b1, 2'd0);
            bus_op(1'b1, 2'd1);
            send_frame(k, 8'h00, 1'b1, -1, -1);
            check_out(k, $sformatf("sweep%0d 00", k), 8'h00, 1'b1, 1'b0, 1'b0);
            idle(16);
            bus_op(1'b1, 2'd0);
            send_frame(k, 8'hFF, 1'b1, -1, -1);
            check_out(k, $sformatf("sweep%0d FF", k), 8'hFF, 1'b1, 1'b0, 1'b0);
            idle(16);
        end

        // Random frames and bus accesses against a frame-level model of the status rules.
        bus_op(1'b1, 2'd0);
        bus_op(1'b1, 2'd1);
        m_data = 8'h81; m_rda = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
        for (int n = 0; n < 24; n++) begin
            op = $urandom_range(0, 4);
            case (op)
                1: begin bus_op(1'b1, 2'd0); m_rda = 1'b0; end
                2: begin bus_op(1'b1, 2'd1); m_fe = 1'b0; m_ov = 1'b0; end
                3: bus_op(1'b0, 2'($urandom_range(0, 3)));
                4: bus_op(1'b1, 2'($urandom_range(2, 3)));
                default: ;
            endcase
            check($sformatf("rand[%0d] rda after op %0d", n, op), {7'd0, if16.rda}, {7'd0, m_rda});
            rb = 8'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            send_frame(0, rb, rs, -1, -1);
            m_ov   = m_ov | m_rda;
            m_rda  = 1'b1;
            m_fe   = m_fe | ~rs;
            m_data = rb;
            check_out(0, $sformatf("rand[%0d]", n), m_data, m_rda, m_fe, m_ov);
            idle(64 * $urandom_range(1, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
